// File: rtl/data_mem_stage_pkg.sv
// Shared types and constants for the MEM-stage data memory.
// Imported by data_mem_array and data_mem_stage.
package data_mem_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  localparam logic SIZE_WORD = 1'b0;
  localparam logic SIZE_BYTE = 1'b1;

  localparam logic RW_LOAD  = 1'b0;
  localparam logic RW_STORE = 1'b1;

  localparam int DEFAULT_ADDR_W = 8;

endpackage

// File: rtl/data_mem_array.sv
// Big-endian byte-addressed storage: synchronous 1- or 4-byte write, combinational read.
// Word accesses ignore addr[1:0]; the storage itself is never reset.
module data_mem_array
  import data_mem_stage_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              size_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [7:0]        mem_q [2**ADDR_W];
  logic [ADDR_W-1:0] base;
  logic [ADDR_W-1:0] addr1;
  logic [ADDR_W-1:0] addr2;
  logic [ADDR_W-1:0] addr3;

  assign base  = {addr_i[ADDR_W-1:2], 2'b00};
  assign addr1 = base + ADDR_W'(1);
  assign addr2 = base + ADDR_W'(2);
  assign addr3 = base + ADDR_W'(3);

  always_ff @(posedge clk) begin
    if (we_i) begin
      if (size_i == SIZE_BYTE) begin
        mem_q[addr_i] <= wdata_i[7:0];
      end else begin
        mem_q[base]  <= wdata_i[31:24];
        mem_q[addr1] <= wdata_i[23:16];
        mem_q[addr2] <= wdata_i[15:8];
        mem_q[addr3] <= wdata_i[7:0];
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    if (size_i == SIZE_BYTE) begin
      rdata_o = {24'h0, mem_q[addr_i]};
    end else begin
      rdata_o = {mem_q[base], mem_q[addr1], mem_q[addr2], mem_q[addr3]};
    end
  end

endmodule

// File: rtl/data_mem_stage.sv
// MEM-stage data memory with WAIT_STATES extra cycles per access and a stall request.
// Optional macro DATA_MEM_MISALIGN_TRAP_EN turns misaligned word accesses into no-op traps.
module data_mem_stage
  import data_mem_stage_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              R,
  input  logic              mem_enable,
  input  logic              mem_rw,
  input  logic              mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_misalign
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rw_q, size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rdata_q;
  logic              done_q;
  logic              misalign_q;

  logic              accept;
  logic              commit;
  logic              cmt_rw, cmt_size;
  logic [ADDR_W-1:0] cmt_addr;
  logic [31:0]       cmt_wdata;
  logic              misalign_c;
  logic              we;
  logic [31:0]       arr_rdata;

  // With zero wait states the request commits on its own edge, so the live inputs are used.
  assign accept    = (state_q == IDLE) && mem_enable;
  assign commit    = R && ((accept && (WS == 4'd0)) || ((state_q == WAIT) && (cnt_q == 4'd1)));
  assign cmt_rw    = (state_q == IDLE) ? mem_rw    : rw_q;
  assign cmt_size  = (state_q == IDLE) ? mem_size  : size_q;
  assign cmt_addr  = (state_q == IDLE) ? mem_addr  : addr_q;
  assign cmt_wdata = (state_q == IDLE) ? mem_wdata : wdata_q;

`ifdef DATA_MEM_MISALIGN_TRAP_EN
  assign misalign_c = commit && (cmt_size == SIZE_WORD) && (cmt_addr[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  assign we = commit && (cmt_rw == RW_STORE) && !misalign_c;

  data_mem_array #(
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk    (clk),
    .we_i   (we),
    .size_i (cmt_size),
    .addr_i (cmt_addr),
    .wdata_i(cmt_wdata),
    .rdata_o(arr_rdata)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rw_q    <= RW_LOAD;
      size_q  <= SIZE_WORD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rw_q    <= mem_rw;
        size_q  <= mem_size;
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (mem_enable && (WS != 4'd0)) begin
          state_d = WAIT;
          cnt_d   = WS;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_busy = 1'b0;
    if ((state_q == IDLE) && mem_enable && (WS != 4'd0)) begin
      mem_busy = 1'b1;
    end else if ((state_q == WAIT) && (cnt_q > 4'd1)) begin
      mem_busy = 1'b1;
    end
  end

  // Load data only moves on a committed, non-trapped load.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      rdata_q    <= '0;
      done_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      done_q     <= commit;
      misalign_q <= misalign_c;
      if (commit && (cmt_rw == RW_LOAD) && !misalign_c) begin
        rdata_q <= arr_rdata;
      end
    end
  end

  assign mem_rdata    = rdata_q;
  assign mem_done     = done_q;
  assign mem_misalign = misalign_q;

endmodule

// File: tb/tb_data_mem_stage.sv
// Randomized self-checking bench for data_mem_stage against a byte-array reference model.
// Two instances: one with two wait states, one with zero wait states.
module tb_data_mem_stage;

  localparam int WS2 = 2;

  logic        clk = 1'b0;
  logic        R   = 1'b0;

  logic        en = 1'b0, rw = 1'b0, sz = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        busy, done, mis;

  logic        en0 = 1'b0, rw0 = 1'b0, sz0 = 1'b0;
  logic [7:0]  addr0 = '0;
  logic [31:0] wdata0 = '0;
  logic [31:0] rdata0;
  logic        busy0, done0, mis0;

  int          nChecks = 0;
  int          nFails  = 0;

  logic [7:0]  mm [2][256];
  logic [31:0] expR  = '0;
  logic [31:0] expR0 = '0;

  always #5 clk = ~clk;

  data_mem_stage #(.ADDR_W(8), .WAIT_STATES(WS2)) dut (
    .clk(clk), .R(R), .mem_enable(en), .mem_rw(rw), .mem_size(sz),
    .mem_addr(addr), .mem_wdata(wdata), .mem_rdata(rdata),
    .mem_busy(busy), .mem_done(done), .mem_misalign(mis)
  );

  data_mem_stage #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .R(R), .mem_enable(en0), .mem_rw(rw0), .mem_size(sz0),
    .mem_addr(addr0), .mem_wdata(wdata0), .mem_rdata(rdata0),
    .mem_busy(busy0), .mem_done(done0), .mem_misalign(mis0)
  );

  // Reference: big-endian byte array, word accesses use the enclosing aligned word.
  function automatic logic [31:0] mRead(int d, logic [7:0] a, logic s);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    if (s) return {24'h0, mm[d][a]};
    return {mm[d][b], mm[d][b + 8'd1], mm[d][b + 8'd2], mm[d][b + 8'd3]};
  endfunction

  function automatic void mWrite(int d, logic [7:0] a, logic s, logic [31:0] w);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    if (s) begin
      mm[d][a] = w[7:0];
    end else begin
      mm[d][b]        = w[31:24];
      mm[d][b + 8'd1] = w[23:16];
      mm[d][b + 8'd2] = w[15:8];
      mm[d][b + 8'd3] = w[7:0];
    end
  endfunction

  function automatic logic misExpected(logic s, logic [7:0] a);
`ifdef DATA_MEM_MISALIGN_TRAP_EN
    return (s == 1'b0) && (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // One full access on the two-wait-state instance; inputs are scrambled while it waits.
  task automatic access(input logic r, input logic s, input logic [7:0] a,
                        input logic [31:0] w, input string nm);
    logic expMis;
    @(negedge clk);
    en = 1'b1; rw = r; sz = s; addr = a; wdata = w;
    #1;
    nChecks++;
    if (busy !== 1'b1) begin
      nFails++; $display("[TB] FAIL %s busy req: got %b expected 1", nm, busy);
    end
    for (int k = 1; k <= WS2; k++) begin
      @(negedge clk);
      en = 1'($urandom); rw = 1'($urandom); sz = 1'($urandom);
      addr = 8'($urandom); wdata = $urandom;
      #1;
      nChecks++;
      if (busy !== (k < WS2)) begin
        nFails++; $display("[TB] FAIL %s busy k=%0d: got %b expected %b", nm, k, busy, (k < WS2));
      end
      nChecks++;
      if (done !== 1'b0) begin
        nFails++; $display("[TB] FAIL %s early done k=%0d: got %b expected 0", nm, k, done);
      end
      nChecks++;
      if (rdata !== expR) begin
        nFails++; $display("[TB] FAIL %s rdata hold k=%0d: got %h expected %h", nm, k, rdata, expR);
      end
    end
    expMis = misExpected(s, a);
    if (!expMis) begin
      if (r) mWrite(0, a, s, w);
      else   expR = mRead(0, a, s);
    end
    @(negedge clk);
    en = 1'b0;
    #1;
    nChecks++;
    if (done !== 1'b1) begin
      nFails++; $display("[TB] FAIL %s done: got %b expected 1", nm, done);
    end
    nChecks++;
    if (rdata !== expR) begin
      nFails++; $display("[TB] FAIL %s rdata: got %h expected %h", nm, rdata, expR);
    end
    nChecks++;
    if (mis !== expMis) begin
      nFails++; $display("[TB] FAIL %s misalign: got %b expected %b", nm, mis, expMis);
    end
  endtask

  task automatic test_reset();
    R = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    nChecks++;
    if (rdata !== 32'h0) begin nFails++; $display("[TB] FAIL reset rdata: got %h expected 0", rdata); end
    nChecks++;
    if (done !== 1'b0) begin nFails++; $display("[TB] FAIL reset done: got %b expected 0", done); end
    nChecks++;
    if (mis !== 1'b0) begin nFails++; $display("[TB] FAIL reset misalign: got %b expected 0", mis); end
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
    nChecks++;
    if (rdata0 !== 32'h0) begin nFails++; $display("[TB] FAIL reset rdata0: got %h expected 0", rdata0); end
    nChecks++;
    if (done0 !== 1'b0) begin nFails++; $display("[TB] FAIL reset done0: got %b expected 0", done0); end
    @(negedge clk);
    R = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 64; i++) access(1'b1, 1'b0, 8'(i * 4), $urandom, "fill");
  endtask

  task automatic test_word_store_load();
    access(1'b1, 1'b0, 8'h10, 32'hDEADBEEF, "st_word");
    access(1'b0, 1'b0, 8'h10, 32'h0, "ld_word");
    nChecks++;
    if (rdata !== 32'hDEADBEEF) begin nFails++; $display("[TB] FAIL ld_word lit: got %h expected deadbeef", rdata); end
    access(1'b0, 1'b1, 8'h12, 32'h0, "ld_byte");
    nChecks++;
    if (rdata !== 32'h000000BE) begin nFails++; $display("[TB] FAIL ld_byte lit: got %h expected 000000be", rdata); end
    access(1'b0, 1'b1, 8'h13, 32'h0, "ld_byte3");
    nChecks++;
    if (rdata !== 32'h000000EF) begin nFails++; $display("[TB] FAIL ld_byte3 lit: got %h expected 000000ef", rdata); end
  endtask

  task automatic test_byte_store();
    access(1'b1, 1'b1, 8'h11, 32'hFFFFFF5A, "st_byte");
    nChecks++;
    if (rdata !== 32'h000000EF) begin nFails++; $display("[TB] FAIL st_byte rdata kept: got %h expected 000000ef", rdata); end
    access(1'b0, 1'b0, 8'h10, 32'h0, "ld_after_byte");
    nChecks++;
    if (rdata !== 32'hDE5ABEEF) begin nFails++; $display("[TB] FAIL ld_after_byte lit: got %h expected de5abeef", rdata); end
  endtask

  task automatic test_misalign_word();
    access(1'b1, 1'b0, 8'hFE, 32'h11223344, "st_misaligned");
    access(1'b0, 1'b0, 8'hFC, 32'h0, "ld_fc");
`ifndef DATA_MEM_MISALIGN_TRAP_EN
    nChecks++;
    if (rdata !== 32'h11223344) begin nFails++; $display("[TB] FAIL ld_fc lit: got %h expected 11223344", rdata); end
`endif
    access(1'b0, 1'b0, 8'hFF, 32'h0, "ld_ff_misaligned");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      access(1'b1 & 1'($urandom), 1'($urandom), 8'($urandom), $urandom, "random");
    end
  endtask

  task automatic test_reset_abort();
    access(1'b1, 1'b0, 8'h20, 32'h01020304, "pre_abort");
    @(negedge clk);
    en = 1'b1; rw = 1'b1; sz = 1'b0; addr = 8'h20; wdata = 32'hCAFEF00D;
    @(negedge clk);
    en = 1'b0;
    #2;
    R = 1'b0;
    #1;
    expR = 32'h0;
    expR0 = 32'h0;
    nChecks++;
    if (busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort busy: got %b expected 0", busy); end
    @(negedge clk);
    R = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      nChecks++;
      if (done !== 1'b0) begin nFails++; $display("[TB] FAIL abort done k=%0d: got %b expected 0", k, done); end
      nChecks++;
      if (rdata !== 32'h0) begin nFails++; $display("[TB] FAIL abort rdata k=%0d: got %h expected 0", k, rdata); end
    end
    access(1'b0, 1'b0, 8'h20, 32'h0, "ld_after_abort");
    nChecks++;
    if (rdata !== 32'h01020304) begin nFails++; $display("[TB] FAIL ld_after_abort lit: got %h expected 01020304", rdata); end
  endtask

  // Zero-wait instance: enable held high, store then load of the same location each pair.
  task automatic test_back_to_back();
    logic [31:0] w;
    logic        s;
    logic [7:0]  a;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      en0 = 1'b1; rw0 = 1'b1; sz0 = 1'b0; addr0 = 8'(i * 4); wdata0 = $urandom;
      mWrite(1, addr0, 1'b0, wdata0);
      #1;
      nChecks++;
      if (busy0 !== 1'b0) begin nFails++; $display("[TB] FAIL fill0 busy i=%0d: got %b expected 0", i, busy0); end
    end
    s = 1'b0; a = 8'h0; w = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      nChecks++;
      if (done0 !== 1'b1) begin nFails++; $display("[TB] FAIL b2b done i=%0d: got %b expected 1", i, done0); end
      nChecks++;
      if (rdata0 !== expR0) begin nFails++; $display("[TB] FAIL b2b rdata i=%0d: got %h expected %h", i, rdata0, expR0); end
      if (i % 2 == 0) begin
        s = 1'($urandom);
        a = 8'($urandom);
        if (!s) a[1:0] = 2'b00;
        w = $urandom;
        en0 = 1'b1; rw0 = 1'b1; sz0 = s; addr0 = a; wdata0 = w;
        mWrite(1, a, s, w);
      end else begin
        en0 = 1'b1; rw0 = 1'b0; sz0 = s; addr0 = a; wdata0 = $urandom;
        expR0 = s ? {24'h0, w[7:0]} : w;
      end
      #1;
      nChecks++;
      if (busy0 !== 1'b0) begin nFails++; $display("[TB] FAIL b2b busy i=%0d: got %b expected 0", i, busy0); end
      nChecks++;
      if (mis0 !== 1'b0) begin nFails++; $display("[TB] FAIL b2b misalign i=%0d: got %b expected 0", i, mis0); end
    end
    @(negedge clk);
    en0 = 1'b0;
    #1;
    nChecks++;
    if (done0 !== 1'b1) begin nFails++; $display("[TB] FAIL b2b last done: got %b expected 1", done0); end
    nChecks++;
    if (rdata0 !== expR0) begin nFails++; $display("[TB] FAIL b2b last rdata: got %h expected %h", rdata0, expR0); end
    nChecks++;
    if (rdata0 !== mRead(1, a, s)) begin nFails++; $display("[TB] FAIL b2b model rdata: got %h expected %h", rdata0, mRead(1, a, s)); end
    @(negedge clk);
    #1;
    nChecks++;
    if (done0 !== 1'b0) begin nFails++; $display("[TB] FAIL b2b idle done: got %b expected 0", done0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_word_store_load();
    test_byte_store();
    test_misalign_word();
    test_random();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- Data memory for the MEM stage of the 5-stage ARM pipeline.
- Consumes the MEM-stage control bits from the EX/MEM register (enable, read/write, size) together with the ALU address and store data.
- Performs big-endian byte/word loads and stores with a configurable number of wait states.
- Drives a stall request to the hazard logic while an access is in progress, and drives load data toward MEM/WB.

Parameters:
ADDR_W, 8, byte-address width; memory depth is 2**ADDR_W bytes.
WAIT_STATES, 2, extra cycles per access (legal range 0..15).

Ports:
clk  in  1  pipeline clock, rising edge.
R  in  1  reset, asynchronous, active-low.
mem_enable  in  1  access request (the MEM-stage Enable_signal).
mem_rw  in  1  0 = load, 1 = store.
mem_size  in  1  0 = word, 1 = byte (the MEM-stage Size_enable).
mem_addr  in  ADDR_W  byte address from the ALU result.
mem_wdata  in  32  store data.
mem_rdata  out  32  load data, registered.
mem_busy  out  1  stall request; the pipeline holds the MEM stage while this is high.
mem_done  out  1  one-cycle pulse when an access commits.
mem_misalign  out  1  misaligned-word pulse; tied 0 when the optional feature is absent.

Behaviour:
- Reset (R=0, asynchronous):
  - state=IDLE, wait counter cleared.
  - mem_rdata=0, mem_done=0, mem_misalign=0.
  - The byte array is not reset.
- Reset asserted mid-access aborts the access: no write occurs and mem_done is not pulsed.
- States are IDLE and WAIT.
- IDLE with mem_enable=1 (request cycle):
  - Latch rw, size, addr and wdata.
  - If WAIT_STATES=0: commit at this edge, stay in IDLE, mem_done=1 in the next cycle.
  - Otherwise: counter<=WAIT_STATES, go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where counter==1: commit at the closing edge, go to IDLE, mem_done=1 in the next cycle.
- mem_busy (combinational):
  - High in the request cycle when WAIT_STATES>0.
  - High in WAIT while counter>1.
  - Low otherwise.
  - Net effect: busy is high for exactly WAIT_STATES cycles, and the pipeline advances on the same edge as the commit.
- Inputs in WAIT:
  - mem_enable and the other inputs are ignored; the latched request always completes.
  - A new request is accepted only in IDLE.
- Latency: commit edge = end of request cycle + WAIT_STATES cycles; mem_done is observed WAIT_STATES+1 cycles after the request cycle.
- Byte ordering is big-endian: Mem[a] = bits [31:24], Mem[a+1] = [23:16], Mem[a+2] = [15:8], Mem[a+3] = [7:0].
- Word access:
  - addr[1:0] are treated as 00.
  - Address arithmetic wraps modulo 2**ADDR_W.
- Byte load: mem_rdata = {24'h0, Mem[addr]} (zero-extended).
- Byte store: Mem[addr] = wdata[7:0]; the other bytes are untouched.
- mem_rdata changes only on a committed load. Stores leave it unchanged, and it holds between accesses.
- Back-to-back store then load to the same address: the load returns the newly stored data.

Optional Feature:
- Macro: DATA_MEM_MISALIGN_TRAP_EN.
- Defined: a word access with addr[1:0]!=00 performs no write and leaves mem_rdata unchanged. It still takes the full latency, and mem_misalign pulses together with mem_done.
- Undefined: addr[1:0] are silently cleared and mem_misalign is constant 0.

Decomposition:
- Shared package holds:
  - state enum (IDLE, WAIT);
  - SIZE_WORD=0, SIZE_BYTE=1;
  - RW_LOAD=0, RW_STORE=1;
  - default ADDR_W.
- One sub-module, data_mem_array:
  - byte storage with a synchronous write of 1 or 4 bytes;
  - combinational big-endian word/byte read;
  - no FSM.

Test Plan:
1. WAIT_STATES=2, word store 0xDEADBEEF at 0x10 -> busy high 2 cycles; done pulses in cycle 3; Mem[0x10..0x13] = DE, AD, BE, EF.
2. Word load 0x10 after test 1 -> mem_rdata=0xDEADBEEF on the done cycle; byte load 0x12 -> 0x000000BE.
3. Byte store 0x5A at 0x11, then word load 0x10 -> 0xDE5ABEEF; mem_rdata unchanged during the store.
4. Word store 0x11223344 at 0xFE:
   - macro undefined -> written to 0xFC..0xFF.
   - macro defined -> mem_misalign pulse, no memory change.
5. R deasserted (pulled low) during the WAIT of a store of 0xCAFEF00D at 0x20 -> state IDLE, no done pulse, Mem[0x20..0x23] unchanged; mem_rdata=0.
6. WAIT_STATES=0, mem_enable held high for alternating store/load on 4 consecutive cycles -> busy never asserts; each load returns the prior store's data one cycle later.
